// File: rtl/operand_frame_loader_if.sv
// operand_frame_loader_if
//   Bundles the operand stream, the parallel frame presented to the adder,
//   and the result handshake of operand_frame_loader.
//   master : the loader itself (drives in_ready, ops_o, ops_valid, res_*)
//   slave  : the surrounding logic (drives in_*, sum_i, res_ready)
// Signals
//   in_valid/in_ready/in_data/in_last : serial operand stream
//   ops_o/ops_valid                    : operand frame, slot i at [i*WIDTH +: WIDTH]
//   sum_i                              : adder output, combinational from ops_o
//   res_valid/res_ready/res_data       : captured sum handshake
//   res_count                          : operands loaded into the frame
interface operand_frame_loader_if #(
   parameter int WIDTH   = 7,
   parameter int NUM_OPS = 8,
   parameter int SUM_W   = 10
);
   localparam int CNT_W = $clog2(NUM_OPS) + 1;

   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0]         in_data;
   logic                     in_last;
   logic [NUM_OPS*WIDTH-1:0] ops_o;
   logic                     ops_valid;
   logic [SUM_W-1:0]         sum_i;
   logic                     res_valid;
   logic                     res_ready;
   logic [SUM_W-1:0]         res_data;
   logic [CNT_W-1:0]         res_count;

   modport master (
      input  in_valid, in_data, in_last, sum_i, res_ready,
      output in_ready, ops_o, ops_valid, res_valid, res_data, res_count
   );

   modport slave (
      output in_valid, in_data, in_last, sum_i, res_ready,
      input  in_ready, ops_o, ops_valid, res_valid, res_data, res_count
   );
endinterface

// File: rtl/operand_frame_loader.sv
// operand_frame_loader
//   Collects operands one per cycle into a parallel frame for the
//   multi-operand adder, holds the frame for SETTLE cycles, captures the
//   adder sum and returns it over a valid/ready result handshake.
// Ports
//   clk : rising-edge clock
//   rst : synchronous reset, active high
//   bus : operand_frame_loader_if.master (operand stream, frame, result)
module operand_frame_loader #(
   parameter int WIDTH   = 7,
   parameter int NUM_OPS = 8,
   parameter int SUM_W   = 10,
   parameter int SETTLE  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   operand_frame_loader_if.master bus
);
   localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
   localparam int CNT_W = $clog2(NUM_OPS) + 1;
   localparam int SET_W = $clog2(SETTLE + 1);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_SETTLE,
      ST_RESULT
   } state_t;

   state_t                         state;
   state_t                         state_nxt;
   logic [IDX_W-1:0]               slot_cnt;
   logic [SET_W-1:0]               settle_cnt;
   logic [NUM_OPS-1:0][WIDTH-1:0]  slots;
   logic [SUM_W-1:0]               res_data_q;
   logic [CNT_W-1:0]               res_count_q;

   logic in_ready_c;
   logic accept;
   logic last_op;
   logic settle_done;
   logic res_hs;

   always_comb begin
      state_nxt   = state;
      in_ready_c  = 1'b0;
      accept      = 1'b0;
      last_op     = 1'b0;
      settle_done = 1'b0;
      res_hs      = 1'b0;

      case (state)
         ST_LOAD: begin
            // in_ready is forced low during reset so nothing is accepted on a reset edge
            in_ready_c = ~rst;
            accept     = bus.in_valid & in_ready_c;
            last_op    = accept & ((slot_cnt == IDX_W'(NUM_OPS - 1)) | bus.in_last);
            if (last_op) state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            settle_done = (settle_cnt == SET_W'(SETTLE - 1));
            if (settle_done) state_nxt = ST_RESULT;
         end
         ST_RESULT: begin
            res_hs = bus.res_ready;
            if (res_hs) state_nxt = ST_LOAD;
         end
         default: state_nxt = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_LOAD;
         slot_cnt    <= '0;
         settle_cnt  <= '0;
         slots       <= '0;
         res_data_q  <= '0;
         res_count_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_LOAD: begin
               if (accept) begin
                  slots[slot_cnt] <= bus.in_data;
                  // counter parks on the last index; it is cleared on the result handshake
                  if (last_op) res_count_q <= CNT_W'(slot_cnt) + CNT_W'(1);
                  else         slot_cnt    <= slot_cnt + IDX_W'(1);
               end
            end
            ST_SETTLE: begin
               if (settle_done) begin
                  settle_cnt <= '0;
                  res_data_q <= bus.sum_i;
               end else begin
                  settle_cnt <= settle_cnt + SET_W'(1);
               end
            end
            ST_RESULT: begin
               // clearing every slot here makes unwritten slots of a short frame read as 0
               if (res_hs) begin
                  slots    <= '0;
                  slot_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.ops_o     = slots;
   assign bus.ops_valid = (state == ST_SETTLE);
   assign bus.res_valid = (state == ST_RESULT);
   assign bus.res_data  = res_data_q;
   assign bus.res_count = res_count_q;
endmodule

// File: tb/tb_operand_frame_loader.sv
module tb_operand_frame_loader;
   localparam int WIDTH   = 7;
   localparam int NUM_OPS = 8;
   localparam int SUM_W   = 10;
   localparam int SETTLE  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   operand_frame_loader_if #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .SUM_W(SUM_W)) bus ();

   operand_frame_loader #(
      .WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .SUM_W(SUM_W), .SETTLE(SETTLE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int                       sum;
      int                       cnt;
      logic [NUM_OPS*WIDTH-1:0] ops;
   } exp_t;
   exp_t sb[$];

   // behavioural adder feeding sum_i
   always_comb begin
      logic [SUM_W-1:0] s;
      s = '0;
      for (int i = 0; i < NUM_OPS; i++) s = s + SUM_W'(bus.ops_o[i*WIDTH +: WIDTH]);
      bus.sum_i = s;
   end

   // res_ready: 0 = held low, 1 = held high, 2 = random per cycle
   int   rr_mode = 1;
   logic rnd_bit = 1'b0;
   always @(posedge clk) begin
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
   end
   assign bus.res_ready = (rr_mode == 2) ? rnd_bit : (rr_mode == 1);

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // monitor: scoreboard pop on result handshake plus timing rules
   int acc_cnt = 0;
   int ov_run  = 0;
   bit expect_ov = 0;
   always @(negedge clk) begin
      if (rst) begin
         acc_cnt   = 0;
         ov_run    = 0;
         expect_ov = 0;
      end else begin
         if (expect_ov) chk("ops_valid_after_last", bus.ops_valid, 1);
         if (bus.ops_valid) ov_run++;
         else if (ov_run != 0) begin
            chk("settle_window_len", ov_run, SETTLE);
            chk("res_valid_after_settle", bus.res_valid, 1);
            ov_run = 0;
         end
         if (bus.ops_valid || bus.res_valid) chk("in_ready_busy", bus.in_ready, 0);
         expect_ov = 0;
         if (bus.in_valid && bus.in_ready) begin
            if (acc_cnt == NUM_OPS - 1 || bus.in_last) begin
               expect_ov = 1;
               acc_cnt   = 0;
            end else acc_cnt++;
         end
         if (bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got %0d expected none", bus.res_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("res_data", bus.res_data, e.sum);
               chk("res_count", bus.res_count, e.cnt);
               chk("ops_o_frame", bus.ops_o, e.ops);
            end
         end
      end
   end

   // Sends one frame; entered and left at posedge+1.
   task automatic run_frame(input int vals[$], input bit use_last, input bit gaps, input bit push);
      exp_t e;
      int   n;
      bit   ok;
      n     = vals.size();
      e.sum = 0;
      e.cnt = n;
      e.ops = '0;
      for (int i = 0; i < n; i++) begin
         e.sum += vals[i];
         e.ops[i*WIDTH +: WIDTH] = WIDTH'(vals[i]);
      end
      for (int i = 0; i < n; i++) begin
         if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = WIDTH'($urandom);
            bus.in_last  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               #1;
            end
         end
         bus.in_valid = 1'b1;
         bus.in_data  = WIDTH'(vals[i]);
         bus.in_last  = use_last && (i == n - 1);
         ok = 0;
         for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
               ok = 1;
               break;
            end
         end
         if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 for operand %0d", i);
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (push) sb.push_back(e);
   endtask

   task automatic drain();
      for (int t = 0; t < 2000 && sb.size() != 0; t++) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int q[$];
      int pending;
      bit ok;

      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_ops_o", bus.ops_o, 0);
      chk("rst_ops_valid", bus.ops_valid, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_data", bus.res_data, 0);
      chk("rst_res_count", bus.res_count, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", bus.in_ready, 1);
      @(posedge clk);
      #1;

      // directed frames
      q = {0, 1, 2, 3, 4, 5, 6, 7};       run_frame(q, 0, 0, 1);   // 28
      q = {1, 1, 1, 1, 1, 1, 1, 1};       run_frame(q, 0, 0, 1);   // 8
      q = {3, 1, 2, 3, 4, 5, 6, 7};       run_frame(q, 0, 0, 1);   // 31
      q = {15, 15, 15, 15, 15, 15, 15, 15}; run_frame(q, 0, 0, 1); // 120
      q = {127, 127, 127, 127, 127, 127, 127, 127}; run_frame(q, 0, 0, 1); // 1016
      q = {5, 6, 7};                      run_frame(q, 1, 0, 1);   // 18, count 3
      q = {9};                            run_frame(q, 1, 0, 1);   // 1-operand frame
      drain();

      // back-pressure on the result with an operand pending
      rr_mode = 0;
      q.delete();
      for (int i = 0; i < NUM_OPS; i++) q.push_back($urandom_range(0, 127));
      run_frame(q, 0, 0, 1);
      ok = 0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (bus.res_valid) begin
            ok = 1;
            break;
         end
      end
      chk("res_valid_seen", ok, 1);
      @(posedge clk);
      #1;
      pending      = $urandom_range(1, 127);
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(pending);
      bus.in_last  = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_res_valid", bus.res_valid, 1);
         if (sb.size() > 0) begin
            chk("bp_res_data", bus.res_data, sb[0].sum);
            chk("bp_ops_o", bus.ops_o, sb[0].ops);
         end
      end
      @(posedge clk);
      #1;
      rr_mode = 1;
      chk("hs_cycle_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
      chk("in_ready_after_hs", bus.in_ready, 1);
      q.delete();
      q.push_back(pending);
      for (int i = 1; i < NUM_OPS; i++) q.push_back($urandom_range(0, 127));
      run_frame(q, 0, 0, 1);
      drain();

      // reset in the middle of a frame
      q = {100, 101, 102, 103};
      run_frame(q, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ops_o", bus.ops_o, 0);
      chk("midrst_ops_valid", bus.ops_valid, 0);
      chk("midrst_res_valid", bus.res_valid, 0);
      chk("midrst_res_data", bus.res_data, 0);
      chk("midrst_res_count", bus.res_count, 0);
      chk("midrst_in_ready_after", bus.in_ready, 1);
      @(posedge clk);
      #1;
      q = {10, 20, 30, 40, 50, 60, 70, 80};
      run_frame(q, 0, 0, 1);   // 360
      drain();

      // randomized frames with idle gaps and random result back-pressure
      rr_mode = 2;
      for (int f = 0; f < 40; f++) begin
         int n;
         n = $urandom_range(1, NUM_OPS);
         q.delete();
         for (int i = 0; i < n; i++) q.push_back($urandom_range(0, 127));
         run_frame(q, (n < NUM_OPS) ? 1'b1 : 1'($urandom_range(0, 1)), 1, 1);
      end
      rr_mode = 1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/operand_frame_loader.md
Name: operand_frame_loader

Overview:
- Upstream operand-collection stage for the 8-operand multi-operand adder.
- Accepts operands serially, one per cycle, over a valid/ready stream and assembles them into a parallel operand frame.
- Presents the frame to the adder for a fixed settle window, captures the adder's sum, and returns it to the consumer over a valid/ready result handshake.
- Lets the combinational adder be driven from a narrow serial source and its result be sampled at a defined cycle.

Parameters:
- WIDTH, 7, bits per operand.
- NUM_OPS, 8, operands per frame. Fixed adder fan-in; must be 2 or more.
- SUM_W, 10, width of sum_i and res_data. Must be at least WIDTH + ceil(log2(NUM_OPS)).
- SETTLE, 2, cycles the frame is held on ops_o before sum_i is captured. Must be 1 or more.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active high.
- in_valid  in  1  operand available.
- in_ready  out  1  loader accepts an operand this cycle.
- in_data  in  WIDTH  operand value, unsigned.
- in_last  in  1  qualifies in_data as the final operand of a short frame.
- ops_o  out  NUM_OPS*WIDTH  operand frame. Slot i is at bits [i*WIDTH +: WIDTH]; slot 0 is the first operand accepted.
- ops_valid  out  1  frame on ops_o is complete and is being summed.
- sum_i  in  SUM_W  adder output, combinational from ops_o.
- res_valid  out  1  res_data holds a captured sum.
- res_ready  in  1  consumer accepts the result.
- res_data  out  SUM_W  captured sum.
- res_count  out  log2(NUM_OPS)+1  number of operands loaded into this frame (1..NUM_OPS).

Behaviour:
- One clock. Reset is synchronous and active-high, using the clk and rst ports.
- Reset values, applied at a clk edge with rst=1:
  - state = LOAD, slot counter = 0, settle counter = 0.
  - ops_o = 0, ops_valid = 0, res_valid = 0, res_data = 0, res_count = 0.
  - in_ready is 0 while rst is high.
- rst has priority over every other event, including reset in the middle of a frame. A partially loaded frame or a pending result is discarded.
- State LOAD:
  - in_ready = 1, ops_valid = 0, res_valid = 0.
  - An operand is accepted when in_valid & in_ready. The slot at the current counter value takes in_data, and the counter increments.
  - The accepted operand is the last one of the frame when the counter equals NUM_OPS-1 or in_last = 1. Go to SETTLE on the next edge and latch res_count = counter+1.
  - in_last on the very first operand gives a 1-operand frame.
  - in_data and in_last are ignored when in_valid = 0.
- State SETTLE:
  - in_ready = 0, ops_valid = 1, ops_o stable.
  - Lasts exactly SETTLE cycles.
  - On the edge ending the last SETTLE cycle, res_data <= sum_i and the state moves to RESULT.
- State RESULT:
  - res_valid = 1, in_ready = 0, ops_valid = 0.
  - ops_o, res_data and res_count are held stable.
  - On res_valid & res_ready: go to LOAD, clear all slots of ops_o to 0, clear the slot counter, and clear res_valid on that same edge.
  - in_ready rises in the cycle after the result handshake. The loader never accepts an operand and hands off a result in the same cycle.
- Short frame: slots that were not written are 0, because every slot is cleared on entry to LOAD. Zero slots contribute nothing to the sum.
- Latency: last operand accepted in cycle k gives the following:
  - ops_valid is high in cycles k+1 .. k+SETTLE.
  - res_valid is high from cycle k+SETTLE+1.
  - Minimum frame period is NUM_OPS+SETTLE+1 cycles.
- No operand is ever dropped. Back-pressure is applied solely through in_ready = 0.
- Arithmetic: the loader does none. Operands are unsigned, and sum_i is captured verbatim at SUM_W bits.

Test Plan:
- Operands 0,1,2,3,4,5,6,7 with in_valid held high → ops_valid high for exactly 2 cycles after the 8th operand, res_data = 28, res_count = 8, res_valid one cycle later. The bench supplies sum_i as a behavioural sum of the slots.
- Frames of all 1s, then 3,1,2,3,4,5,6,7, then all 15s, with res_ready=1 → res_data = 8, 31, 120 in order, and in_ready low between each frame.
- Eight operands of 127 → res_data = 1016, with no truncation at SUM_W = 10.
- Short frame 5,6,7 with in_last on the 7 → slots 3..7 of ops_o are 0, res_data = 18, res_count = 3.
- Hold res_ready = 0 for 5 cycles while in_valid = 1 → res_data and ops_o stable, in_ready = 0, no operand consumed. After res_ready = 1, in_ready rises the next cycle and slot 0 takes the pending operand.
- Assert rst after 4 operands have been accepted → all outputs return to their reset values. A fresh 8-operand frame then produces the correct sum with no residue from the aborted frame.
